// File: rtl/chip_ctrl_pkg.sv
// Shared definitions for the Chip burst controller.
//   state_t    : controller FSM states (IDLE, ACT, BURST, PRE)
//   bank_index : flat bank number from bank group and bank-in-group
//   col_wrap   : column of beat `beat` when wrapping inside a BL-aligned block
package chip_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACT   = 2'd1,
    BURST = 2'd2,
    PRE   = 2'd3
  } state_t;

  function automatic int bank_index(input int bg, input int ba, input int bawidth);
    return bg * (2 ** bawidth) + ba;
  endfunction

  // bl is a power of two: the low log2(bl) bits advance modulo bl,
  // the upper column bits stay fixed.
  function automatic logic [31:0] col_wrap(input logic [31:0] col, input int beat, input int bl);
    logic [31:0] mask;
    mask = 32'(bl - 1);
    return (col & ~mask) | ((col + 32'(beat)) & mask);
  endfunction

endpackage

// File: rtl/chip_rd_capture.sv
// Read-data capture pipeline.
// Each read beat launched by the controller travels RL stages as {valid, slot};
// when it reaches the last stage, the selected bank's dqout is written into
// that slot of rdata. Capturing slot BL-1 raises rdata_valid for one cycle.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   launch       : a read beat is driven on the bank this cycle
//   launch_slot  : beat index of that beat
//   beat         : chip_dqout of the target bank
//   rdata        : assembled read word, beat k at [k*DEVICE_WIDTH +: DEVICE_WIDTH]
//   rdata_valid  : one-cycle strobe after the final slot is written
//   pending      : a beat is still in flight and is not captured on this edge
module chip_rd_capture #(
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int RL           = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       launch,
  input  logic [$clog2(BL)-1:0]      launch_slot,
  input  logic [DEVICE_WIDTH-1:0]    beat,
  output logic [DEVICE_WIDTH*BL-1:0] rdata,
  output logic                       rdata_valid,
  output logic                       pending
);

  localparam int SW = $clog2(BL);
  localparam logic [SW-1:0] LAST_SLOT = SW'(BL - 1);

  logic [RL-1:0]         stage_v;
  logic [RL-1:0][SW-1:0] stage_s;

  // The last stage is consumed on the coming edge, so it does not count
  // as outstanding work for the controller.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RL - 1; i++) pending = pending | stage_v[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v     <= '0;
      stage_s     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      stage_v[0] <= launch;
      stage_s[0] <= launch_slot;
      for (int i = 1; i < RL; i++) begin
        stage_v[i] <= stage_v[i-1];
        stage_s[i] <= stage_s[i-1];
      end
      if (stage_v[RL-1]) rdata[stage_s[RL-1]*DEVICE_WIDTH +: DEVICE_WIDTH] <= beat;
      rdata_valid <= stage_v[RL-1] && (stage_s[RL-1] == LAST_SLOT);
    end
  end

endmodule

// File: rtl/chip_burst_ctrl.sv
// Single-requester burst sequencer in front of the Chip bank array.
// One read or write burst at a time: ACT (row drive, TRCD cycles), BURST
// (BL column beats wrapping in the BL-aligned block), PRE (TRP cycles, plus
// any read capture still in flight), then IDLE.
// Optional build macro CHIP_CTRL_OPEN_ROW_EN: open-row policy; rows stay open
// after a burst, a same-row hit skips ACT, a row miss runs PRE then ACT.
// Handshake: a command transfers on a rising edge where req_valid && req_ready;
// req_ready is high exactly in IDLE and the requester holds the command stable
// until it transfers.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   req_valid/req_ready               : command handshake
//   req_write, req_bg, req_ba,
//   req_row, req_col, req_wdata       : command fields (registered on accept)
//   rdata, rdata_valid                : assembled read word and its strobe
//   busy                              : FSM not in IDLE
//   dbg_state                         : current FSM state (state_t encoding)
//   chip_rd_o_wr/row/column/dqin      : per-bank drives, bank = bg*2**BAWIDTH+ba
//   chip_dqout                        : per-bank read data
module chip_burst_ctrl
  import chip_ctrl_pkg::*;
#(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int TRCD         = 2,
  parameter int TRP          = 2,
  parameter int RL           = 1,
  localparam int NB          = 2 ** (BGWIDTH + BAWIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [BGWIDTH-1:0]           req_bg,
  input  logic [BAWIDTH-1:0]           req_ba,
  input  logic [CHWIDTH-1:0]           req_row,
  input  logic [COLWIDTH-1:0]          req_col,
  input  logic [DEVICE_WIDTH*BL-1:0]   req_wdata,
  output logic [DEVICE_WIDTH*BL-1:0]   rdata,
  output logic                         rdata_valid,
  output logic                         busy,
  output logic [1:0]                   dbg_state,
  output logic [NB-1:0]                chip_rd_o_wr,
  output logic [NB*CHWIDTH-1:0]        chip_row,
  output logic [NB*COLWIDTH-1:0]       chip_column,
  output logic [NB*DEVICE_WIDTH-1:0]   chip_dqin,
  input  logic [NB*DEVICE_WIDTH-1:0]   chip_dqout
);

  localparam int BIW  = BGWIDTH + BAWIDTH;
  localparam int SW   = $clog2(BL);
  localparam int CNTW = 16;

  state_t                    state;
  logic [CNTW-1:0]           cnt;
  logic [BIW-1:0]            bank_q;
  logic                      write_q;
  logic [CHWIDTH-1:0]        row_q;
  logic [COLWIDTH-1:0]       col_q;
  logic [DEVICE_WIDTH*BL-1:0] wdata_q;

  logic [BIW-1:0]            req_bank;
  logic [SW-1:0]             nbeat;
  logic [COLWIDTH-1:0]       col_src;
  logic [COLWIDTH-1:0]       nxt_col;
  logic [DEVICE_WIDTH*BL-1:0] wdata_src;
  logic                      write_src;
  logic [DEVICE_WIDTH-1:0]   nxt_dq;
  logic                      launch;
  logic                      pending;
  logic                      pre_done;
  logic [DEVICE_WIDTH-1:0]   dq_beat;

`ifdef CHIP_CTRL_OPEN_ROW_EN
  logic [NB-1:0]              open_q;
  logic [NB-1:0][CHWIDTH-1:0] open_row_q;
  logic                       precharge_q;  // PRE really closes the row
  logic                       act_after_pre_q;  // row miss: PRE then ACT
  assign pre_done = (!precharge_q || cnt >= CNTW'(TRP - 1)) && !pending;
`else
  assign pre_done = (cnt >= CNTW'(TRP - 1)) && !pending;
`endif

  assign req_bank  = BIW'(bank_index(int'(req_bg), int'(req_ba), BAWIDTH));
  assign dbg_state = state;
  assign launch    = (state == BURST) && !write_q;
  assign dq_beat   = chip_dqout[bank_q*DEVICE_WIDTH +: DEVICE_WIDTH];

  // Outputs are registered, so each edge loads the beat for the NEXT cycle:
  // beat 0 when entering BURST (or on an open-row hit from IDLE), cnt+1 inside.
  always_comb begin
    nbeat     = (state == BURST) ? cnt[SW-1:0] + SW'(1) : '0;
    col_src   = (state == IDLE) ? req_col   : col_q;
    wdata_src = (state == IDLE) ? req_wdata : wdata_q;
    write_src = (state == IDLE) ? req_write : write_q;
    nxt_col   = COLWIDTH'(col_wrap(32'(col_src), int'(nbeat), BL));
    nxt_dq    = write_src ? wdata_src[nbeat*DEVICE_WIDTH +: DEVICE_WIDTH] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bank_q       <= '0;
      write_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      wdata_q      <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      chip_rd_o_wr <= '0;
      chip_row     <= '0;
      chip_column  <= '0;
      chip_dqin    <= '0;
`ifdef CHIP_CTRL_OPEN_ROW_EN
      open_q          <= '0;
      open_row_q      <= '0;
      precharge_q     <= 1'b1;
      act_after_pre_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone accepts.
          if (req_valid) begin
            bank_q    <= req_bank;
            write_q   <= req_write;
            row_q     <= req_row;
            col_q     <= req_col;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
`ifdef CHIP_CTRL_OPEN_ROW_EN
            if (open_q[req_bank] && open_row_q[req_bank] == req_row) begin
              state <= BURST;
              chip_column[req_bank*COLWIDTH +: COLWIDTH]       <= nxt_col;
              chip_rd_o_wr[req_bank]                           <= req_write;
              chip_dqin[req_bank*DEVICE_WIDTH +: DEVICE_WIDTH] <= nxt_dq;
            end else if (open_q[req_bank]) begin
              state           <= PRE;
              precharge_q     <= 1'b1;
              act_after_pre_q <= 1'b1;
              open_q[req_bank] <= 1'b0;
              chip_row[req_bank*CHWIDTH +: CHWIDTH] <= '0;
            end else begin
              state <= ACT;
              open_q[req_bank]     <= 1'b1;
              open_row_q[req_bank] <= req_row;
              chip_row[req_bank*CHWIDTH +: CHWIDTH] <= req_row;
            end
`else
            state <= ACT;
            chip_row[req_bank*CHWIDTH +: CHWIDTH] <= req_row;
`endif
          end
        end
        ACT: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(TRCD - 1)) begin
            state <= BURST;
            cnt   <= '0;
            chip_column[bank_q*COLWIDTH +: COLWIDTH]       <= nxt_col;
            chip_rd_o_wr[bank_q]                           <= write_q;
            chip_dqin[bank_q*DEVICE_WIDTH +: DEVICE_WIDTH] <= nxt_dq;
          end
        end
        BURST: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(BL - 1)) begin
            state <= PRE;
            cnt   <= '0;
            chip_column[bank_q*COLWIDTH +: COLWIDTH]       <= '0;
            chip_rd_o_wr[bank_q]                           <= 1'b0;
            chip_dqin[bank_q*DEVICE_WIDTH +: DEVICE_WIDTH] <= '0;
`ifdef CHIP_CTRL_OPEN_ROW_EN
            // Row stays open; PRE only waits out in-flight read captures.
            precharge_q     <= 1'b0;
            act_after_pre_q <= 1'b0;
`else
            chip_row[bank_q*CHWIDTH +: CHWIDTH] <= '0;
`endif
          end else begin
            chip_column[bank_q*COLWIDTH +: COLWIDTH]       <= nxt_col;
            chip_dqin[bank_q*DEVICE_WIDTH +: DEVICE_WIDTH] <= nxt_dq;
          end
        end
        PRE: begin
          cnt <= cnt + CNTW'(1);
          if (pre_done) begin
            cnt <= '0;
`ifdef CHIP_CTRL_OPEN_ROW_EN
            if (act_after_pre_q) begin
              state           <= ACT;
              act_after_pre_q <= 1'b0;
              open_q[bank_q]     <= 1'b1;
              open_row_q[bank_q] <= row_q;
              chip_row[bank_q*CHWIDTH +: CHWIDTH] <= row_q;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end
`else
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  chip_rd_capture #(
    .DEVICE_WIDTH(DEVICE_WIDTH),
    .BL          (BL),
    .RL          (RL)
  ) u_rd_capture (
    .clk        (clk),
    .rst        (rst),
    .launch     (launch),
    .launch_slot(cnt[SW-1:0]),
    .beat       (dq_beat),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .pending    (pending)
  );

endmodule

// File: doc/chip_burst_ctrl.md
Name: chip_burst_ctrl

Overview:
- Single-requester burst sequencer in front of the Chip bank array.
- Accepts one read or write burst command at a time via valid/ready.
- Drives per-bank rd_o_wr/row/column/dqin with activate delay, BL column beats and precharge delay.
- Collects read beats from dqout into one BL-wide read word.

Parameters:
- BGWIDTH, 2, bank-group address bits.
- BAWIDTH, 2, bank-in-group address bits.
- COLWIDTH, 10, column address bits.
- CHWIDTH, 5, row address bits.
- DEVICE_WIDTH, 4, data bits per beat.
- BL, 8, burst length; power of two, at least 2.
- TRCD, 2, idle cycles between row drive and first column beat; at least 1.
- TRP, 2, idle cycles after the last beat before the next command is accepted; at least 1.
- RL, 1, cycles from a column beat being driven to its dqout sample; at least 1.
- Derived: NB = 2**(BGWIDTH+BAWIDTH).

Ports:
- clk, in, 1, clock; all state on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, command valid.
- req_ready, out, 1, controller can accept a command.
- req_write, in, 1, 1 = write, 0 = read.
- req_bg, in, BGWIDTH, target bank group.
- req_ba, in, BAWIDTH, target bank.
- req_row, in, CHWIDTH, target row.
- req_col, in, COLWIDTH, start column.
- req_wdata, in, DEVICE_WIDTH*BL, write beats; beat k occupies bits [k*DEVICE_WIDTH +: DEVICE_WIDTH].
- rdata, out, DEVICE_WIDTH*BL, read beats, same packing as req_wdata.
- rdata_valid, out, 1, one-cycle strobe marking rdata valid.
- busy, out, 1, state is not IDLE.
- chip_rd_o_wr, out, NB, per-bank write enable; bank index = bg*2**BAWIDTH + ba.
- chip_row, out, NB*CHWIDTH, per-bank row.
- chip_column, out, NB*COLWIDTH, per-bank column.
- chip_dqin, out, NB*DEVICE_WIDTH, per-bank write data.
- chip_dqout, in, NB*DEVICE_WIDTH, per-bank read data.

Behaviour:
- Reset:
  - State goes to IDLE; all chip_* outputs go to 0.
  - rdata = 0, rdata_valid = 0, busy = 0, req_ready = 1.
  - Reset in mid-operation drops the burst; no rdata_valid follows.
- Handshake:
  - A command is accepted when req_valid && req_ready.
  - All req_* fields, including req_wdata, are registered in that cycle.
  - req_ready = 1 only in IDLE.
- State ACT (TRCD cycles):
  - Drives chip_row[bank] = row.
  - Holds chip_column[bank] = 0 and chip_rd_o_wr[bank] = 0.
- State BURST (exactly BL cycles, beat b = 0..BL-1):
  - chip_column[bank] = {col[COLWIDTH-1:log2 BL], (col[log2 BL-1:0] + b) mod BL}, i.e. wrap within the BL-aligned block.
  - Write: chip_rd_o_wr[bank] = 1 and chip_dqin[bank] = beat b.
  - Read: chip_rd_o_wr[bank] = 0.
- Read capture:
  - The beat driven at cycle t is sampled from chip_dqout[bank] at cycle t+RL into slot b.
  - rdata_valid pulses for one cycle after the last slot is captured.
  - rdata holds its value until the next read completes.
- State PRE (TRP cycles):
  - All outputs for the bank return to 0.
  - Read capture still in flight continues.
  - Exit to IDLE only when TRP has elapsed and all RL captures are done.
- Non-target banks: all chip_* fields stay 0 at all times.
- Back-to-back commands: minimum accept-to-accept spacing = 1 + TRCD + BL + max(TRP, RL) cycles.
- req_valid asserted while busy: the command is not accepted and must be held by the requester.

Optional Feature:
- CHIP_CTRL_OPEN_ROW_EN
- Defined (open-row policy):
  - A per-bank open flag and open-row register are kept.
  - On accept, if the target bank is open on the same row, ACT is skipped and BURST starts on the next cycle.
  - After BURST, chip_row[bank] stays driven; PRE is skipped unless the next command targets that bank with a different row.
  - A row miss on an open bank runs PRE (TRP), then ACT.
  - Reset clears all open flags.
- Undefined: closed-page behaviour as described in Behaviour.

Decomposition:
- Package chip_ctrl_pkg:
  - State enum {IDLE, ACT, BURST, PRE}.
  - Bank-index function bg*2**BAWIDTH + ba.
  - Column-wrap function.
- Sub-module chip_rd_capture: RL-deep shift register of {valid, slot} that writes the rdata slots and generates rdata_valid.

Test Plan:
- Write burst: bg=1, ba=1, row=1, col=0, write, beats 0x1..0x8.
  - Bank 5 shows TRCD=2 ACT cycles, then 8 cycles with rd_o_wr=1, column 0..7, dqin 1..8.
  - All other banks stay 0.
- Readback: read of the same address follows.
  - rdata = 0x87654321 (beat0 in the LSBs).
  - rdata_valid pulses once, 1+2+8+RL cycles after accept.
- Wrap: col=5 → columns 5,6,7,0,1,2,3,4.
  - col=13 → columns 13,14,15,8..12.
- Back-to-back: req_valid held high with two commands.
  - req_ready low for exactly 12 cycles (TRCD=2, BL=8, TRP=2) between the two accepts.
- Reset in mid-BURST: rst asserted at beat 3.
  - All chip_* outputs go to 0 immediately (asynchronously).
  - No rdata_valid; req_ready=1 after release.
- CHIP_CTRL_OPEN_ROW_EN: two reads to bank 5, row 1.
  - Second read has no ACT cycles.
  - A third read to row 2 shows PRE, then ACT.
